// File: rtl/gray_to_bin_nbits_if.sv
// Handshake bundle for the Gray-to-binary decoder.
//   in_valid/in_ready/in_grey            : upstream Gray word stream
//   out_valid/out_ready/out_bin/out_step_err : downstream decoded stream
// master : the side that feeds words in and consumes results.
// slave  : the decoder itself.
interface gray_to_bin_nbits_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_grey;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_bin;
  logic         out_step_err;

  modport master (
    output in_valid, in_grey, out_ready,
    input  in_ready, out_valid, out_bin, out_step_err
  );

  modport slave (
    input  in_valid, in_grey, out_ready,
    output in_ready, out_valid, out_bin, out_step_err
  );
endinterface

// File: rtl/gray_to_bin_nbits.sv
// Registered, handshaked Gray-to-binary decoder with single-bit-step check.
// Each accepted N-bit Gray word is decoded to binary and presented one cycle
// later. Consecutive accepted words must differ in exactly one bit; any
// violation is flagged alongside the word and counted in a saturating counter.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : handshake bundle (slave side), see gray_to_bin_nbits_if
//   err_count: saturating count of step violations since reset / last clear
//   clr_err  : synchronous clear of err_count
module gray_to_bin_nbits #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_to_bin_nbits_if.slave   bus,
  output logic [CW-1:0]        err_count,
  input  logic                 clr_err
);

  logic [N-1:0] bin;
  logic [N-1:0] prev_grey;
  logic         has_prev;
  logic         out_valid;
  logic [N-1:0] out_bin;
  logic         out_step_err;
  logic         step_err;
  logic         accept;
  logic         xfer;

  // Prefix XOR from the MSB down: each binary bit is the parity of all Gray
  // bits at or above it.
  always_comb begin
    bin        = '0;
    bin[N-1]   = bus.in_grey[N-1];
    for (int i = N - 2; i >= 0; i--)
      bin[i] = bin[i+1] ^ bus.in_grey[i];
  end

  // A legal step flips exactly one bit; a repeated word (no bits flipped)
  // counts as a violation too.
  assign step_err = has_prev && !$onehot(bus.in_grey ^ prev_grey);

  // Single output register: a new word may enter whenever the slot is empty
  // or is being drained this cycle, giving one word per cycle without skid.
  assign bus.in_ready = !out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_bin      <= '0;
      out_step_err <= 1'b0;
      prev_grey    <= '0;
      has_prev     <= 1'b0;
      err_count    <= '0;
    end else begin
      if (accept) begin
        out_bin      <= bin;
        out_step_err <= step_err;
        out_valid    <= 1'b1;
        prev_grey    <= bus.in_grey;
        has_prev     <= 1'b1;
      end else if (xfer) begin
        out_valid    <= 1'b0;
      end

      // Clear beats a same-cycle increment; counter sticks at all-ones.
      if (clr_err)
        err_count <= '0;
      else if (accept && step_err && (err_count != {CW{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

  assign bus.out_valid    = out_valid;
  assign bus.out_bin      = out_bin;
  assign bus.out_step_err = out_step_err;

endmodule

// File: doc/gray_to_bin_nbits.md
Name: gray_to_bin_nbits

Overview:
- Registered, handshaked Gray-to-binary decoder. It is the inverse of the team's bin-to-grey encoder.
- Sits at the receive end of Gray-coded pointer and counter paths. Typical sources are CDC-synchronised FIFO pointers and position counters.
- Decodes each accepted N-bit Gray word to binary with one cycle of latency.
- Checks that consecutive accepted words differ in exactly one bit, and keeps a saturating count of violations.

Parameters:
- N, 8, data width in bits (N >= 2).
- CW, 8, width of the error counter in bits (CW >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_grey is presented.
- in_ready  output  1  block can accept a word this cycle.
- in_grey  input  N  Gray-coded input word.
- out_valid  output  1  out_bin/out_step_err hold a decoded result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_bin  output  N  decoded binary value.
- out_step_err  output  1  the word in out_bin violated the single-bit-step rule.
- err_count  output  CW  saturating count of step violations since reset.
- clr_err  input  1  synchronous clear of err_count.

Behaviour:
- Reset (rst=1 at a rising edge) sets: out_valid=0, out_bin=0, out_step_err=0, err_count=0, has_prev=0, prev_grey=0. Reset has priority over every other event.
- Reset while out_valid=1 discards the pending result. No output handshake completes in that cycle.
- Decode function:
  - bin[N-1] = g[N-1].
  - bin[i] = bin[i+1] XOR g[i], for i = N-2 down to 0.
  - Purely combinational ahead of the output register.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational; no skid storage is needed.
  - Accept: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - out_bin and out_step_err are held stable while out_valid=1 && out_ready=0.
- Output register update, at each rising edge when rst=0:
  - Accept: out_bin <= decode(in_grey), out_step_err <= step_err, out_valid <= 1.
  - Otherwise, on an output transfer: out_valid <= 0. out_bin and out_step_err keep their last values.
  - Simultaneous output transfer and accept: the new word is loaded and out_valid stays 1. This gives full throughput, one word per cycle.
- Latency: a word accepted at edge k appears with out_valid=1 immediately after edge k (a 1-cycle register).
- Step check:
  - d = in_grey XOR prev_grey.
  - step_err = has_prev && (popcount(d) != 1).
  - Repeated identical words (d=0) are violations.
  - The first word after reset is never flagged. The first word after clr_err is flagged normally.
  - On each accept: prev_grey <= in_grey and has_prev <= 1.
  - Wrap-around is legal: max code to 0 differs in bit N-1 only.
- err_count:
  - On an accept with step_err=1, err_count increments by 1.
  - It saturates at 2^CW-1 and never wraps.
  - clr_err=1 sets err_count to 0 at the edge.
  - clr_err in the same cycle as a flagged accept: the clear wins and err_count=0. out_step_err for that word is still 1.
  - clr_err does not affect prev_grey, has_prev or the data path.
- No internal state depends on out_ready other than out_valid.

Test Plan (N=8, CW=8 unless stated):
- Reset, then in_valid=1, in_grey=0x0C, out_ready=1 → next cycle out_valid=1, out_bin=0x08, out_step_err=0, err_count=0.
- Stream Gray codes of 0..255 and back to 0 (255→0 is gray 0x80→0x00), one per cycle, with out_ready=1 → in_ready is 1 throughout, out_bin = 0,1,…,255,0 on consecutive cycles, out_step_err is never set, and err_count=0.
- Backpressure: send 0x00 then 0x01 with out_ready=0 for 3 cycles.
  - in_ready=0 after the first accept, and out_bin=0x00 is held stable.
  - Raise out_ready → 0x00 transfers and 0x01 is accepted in the same cycle.
  - Next cycle out_bin=0x01.
- Step violations: send 0x00, 0x03, 0x03, 0x80.
  - out_step_err = 0, 1, 1, 1.
  - err_count = 3.
  - Assert clr_err together with one further flagged word → err_count=0 and that word's out_step_err=1.
- Saturation with CW=2: five consecutive flagged accepts → err_count reads 1, 2, 3, 3, 3.
- Reset mid-stream with out_valid=1, out_ready=0 and in_grey=0x80 pending.
  - Next cycle: out_valid=0, out_bin=0, err_count=0.
  - The first word after reset (0x55) is not flagged, and out_bin=0x66.
